// File: rtl/gyro_pkg.sv
// Shared register map, command-byte layout and responder state encoding for the
// gyro SPI emulation; the master FSM uses the same constants.
package gyro_pkg;

  localparam logic [5:0] WHO_AM_I  = 6'h0F;
  localparam logic [5:0] CTRL_REG1 = 6'h20;
  localparam logic [5:0] CTRL_REG2 = 6'h21;
  localparam logic [5:0] CTRL_REG3 = 6'h22;
  localparam logic [5:0] CTRL_REG4 = 6'h23;
  localparam logic [5:0] CTRL_REG5 = 6'h24;
  localparam logic [5:0] OUT_TEMP  = 6'h26;
  localparam logic [5:0] OUT_X_L   = 6'h28;
  localparam logic [5:0] OUT_X_H   = 6'h29;
  localparam logic [5:0] OUT_Y_L   = 6'h2A;
  localparam logic [5:0] OUT_Y_H   = 6'h2B;
  localparam logic [5:0] OUT_Z_L   = 6'h2C;
  localparam logic [5:0] OUT_Z_H   = 6'h2D;

  localparam int CMD_RW_BIT = 7;
  localparam int CMD_MS_BIT = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_READ,
    ST_WRITE
  } resp_state_t;

endpackage

// File: rtl/gyro_spi_responder_shifter.sv
// SPI mode-3 slave bit engine: synchronizes the pins, detects edges, assembles
// received bytes and shifts out a loaded transmit byte on sclk falling edges.
module spi_slave_shifter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       ss_n,
  input  logic       mosi,
  input  logic       tx_load,
  input  logic [7:0] tx_byte,
  output logic       sel_fall,
  output logic       sel_rise,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       miso
);

  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] ss_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic       sclk_prev_reg;
  logic       ss_prev_reg;
  logic       active_reg;
  logic [2:0] bit_cnt_reg;
  logic [6:0] rx_shift_reg;
  logic [7:0] tx_shift_reg;
  logic [7:0] rx_byte_reg;
  logic       rx_valid_reg;
  logic       miso_reg;

  logic sclk_s, ss_s, mosi_s, sclk_rise, sclk_fall;

  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign ss_s      = ss_sync_reg[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
  assign sel_fall  = ~ss_s & ss_prev_reg;
  assign sel_rise  = ss_s & ~ss_prev_reg;
  assign sclk_rise = active_reg & sclk_s & ~sclk_prev_reg;
  assign sclk_fall = active_reg & ~sclk_s & sclk_prev_reg;

  assign rx_valid = rx_valid_reg;
  assign rx_byte  = rx_byte_reg;
  assign miso     = miso_reg;

  // ss_n chain resets low so a frame still in progress when rst drops never
  // looks like a fresh select; only a genuine later fall starts a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_reg <= '1;
      ss_sync_reg   <= '0;
      mosi_sync_reg <= '0;
      sclk_prev_reg <= 1'b1;
      ss_prev_reg   <= 1'b0;
      active_reg    <= 1'b0;
      bit_cnt_reg   <= 3'd0;
      rx_shift_reg  <= 7'd0;
      tx_shift_reg  <= 8'd0;
      rx_byte_reg   <= 8'd0;
      rx_valid_reg  <= 1'b0;
      miso_reg      <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
      ss_sync_reg   <= {ss_sync_reg[SYNC_STAGES-2:0], ss_n};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
      sclk_prev_reg <= sclk_s;
      ss_prev_reg   <= ss_s;
      rx_valid_reg  <= 1'b0;
      if (sel_fall || sel_rise) begin
        active_reg   <= sel_fall;
        bit_cnt_reg  <= 3'd0;
        rx_shift_reg <= 7'd0;
        tx_shift_reg <= 8'd0;
        miso_reg     <= 1'b0;
      end else begin
        if (sclk_rise) begin
          rx_shift_reg <= {rx_shift_reg[5:0], mosi_s};
          bit_cnt_reg  <= bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            rx_valid_reg <= 1'b1;
            rx_byte_reg  <= {rx_shift_reg, mosi_s};
          end
        end
        if (tx_load) begin
          tx_shift_reg <= tx_byte;
        end else if (sclk_fall) begin
          miso_reg     <= tx_shift_reg[7];
          tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/gyro_spi_responder.sv
// SPI slave emulating the 3-axis gyro register map: command decode, coherent
// axis snapshot per frame, read mux and writable control registers.
module gyro_spi_responder
  import gyro_pkg::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] WHO_AM_I_VAL = 8'hD3,
  parameter logic [7:0] CTRL1_RST    = 8'h07
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        ss_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic [15:0] z_in,
  input  logic [7:0]  temp_in,
  output logic [7:0]  ctrl_reg1,
  output logic [7:0]  ctrl_reg2,
  output logic [7:0]  ctrl_reg3,
  output logic [7:0]  ctrl_reg4,
  output logic [7:0]  ctrl_reg5,
  output logic        wr_strobe,
  output logic [5:0]  wr_addr,
  output logic        busy
);

  resp_state_t state_reg, state_next;
  logic [5:0]  addr_reg, addr_next;
  logic        ms_reg, ms_next;
  logic [15:0] x_sh_reg, y_sh_reg, z_sh_reg;
  logic [7:0]  temp_sh_reg;
  logic        busy_reg;
  logic        wr_strobe_reg;
  logic [5:0]  wr_addr_reg;
  logic [7:0]  ctrl_q [5];

  logic       sel_fall, sel_rise, rx_valid, tx_load, commit;
  logic [7:0] rx_byte, rd_data;
  logic [5:0] cmd_addr, access_addr;

  spi_slave_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .tx_load  (tx_load),
    .tx_byte  (rd_data),
    .sel_fall (sel_fall),
    .sel_rise (sel_rise),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .miso     (miso)
  );

  assign cmd_addr    = rx_byte[5:0];
  // The first read byte comes straight from the command; later ones from the pointer.
  assign access_addr = (state_reg == ST_CMD) ? cmd_addr : addr_reg;

  always_comb begin
    rd_data = 8'h00;
    case (access_addr)
      WHO_AM_I:  rd_data = WHO_AM_I_VAL;
      CTRL_REG1: rd_data = ctrl_q[0];
      CTRL_REG2: rd_data = ctrl_q[1];
      CTRL_REG3: rd_data = ctrl_q[2];
      CTRL_REG4: rd_data = ctrl_q[3];
      CTRL_REG5: rd_data = ctrl_q[4];
      OUT_TEMP:  rd_data = temp_sh_reg;
      OUT_X_L:   rd_data = x_sh_reg[7:0];
      OUT_X_H:   rd_data = x_sh_reg[15:8];
      OUT_Y_L:   rd_data = y_sh_reg[7:0];
      OUT_Y_H:   rd_data = y_sh_reg[15:8];
      OUT_Z_L:   rd_data = z_sh_reg[7:0];
      OUT_Z_H:   rd_data = z_sh_reg[15:8];
      default:   rd_data = 8'h00;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    ms_next    = ms_reg;
    tx_load    = 1'b0;
    commit     = 1'b0;
    if (sel_rise) begin
      state_next = ST_IDLE;
    end else if (sel_fall) begin
      state_next = ST_CMD;
      addr_next  = 6'd0;
      ms_next    = 1'b0;
    end else if (rx_valid) begin
      case (state_reg)
        ST_CMD: begin
          ms_next = rx_byte[CMD_MS_BIT];
          if (rx_byte[CMD_RW_BIT]) begin
            state_next = ST_READ;
            tx_load    = 1'b1;
            addr_next  = cmd_addr + {5'd0, rx_byte[CMD_MS_BIT]};
          end else begin
            state_next = ST_WRITE;
            addr_next  = cmd_addr;
          end
        end
        ST_READ: begin
          tx_load   = 1'b1;
          addr_next = addr_reg + {5'd0, ms_reg};
        end
        ST_WRITE: begin
          commit    = 1'b1;
          addr_next = addr_reg + {5'd0, ms_reg};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= 6'd0;
      ms_reg        <= 1'b0;
      x_sh_reg      <= 16'd0;
      y_sh_reg      <= 16'd0;
      z_sh_reg      <= 16'd0;
      temp_sh_reg   <= 8'd0;
      busy_reg      <= 1'b0;
      wr_strobe_reg <= 1'b0;
      wr_addr_reg   <= 6'd0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      ms_reg        <= ms_next;
      wr_strobe_reg <= commit;
      if (commit) wr_addr_reg <= addr_reg;
      if (sel_rise) begin
        busy_reg <= 1'b0;
      end else if (sel_fall) begin
        busy_reg    <= 1'b1;
        x_sh_reg    <= x_in;
        y_sh_reg    <= y_in;
        z_sh_reg    <= z_in;
        temp_sh_reg <= temp_in;
      end
    end
  end

  for (genvar gi = 0; gi < 5; gi++) begin : g_ctrl
    localparam logic [5:0] REG_ADDR = CTRL_REG1 + 6'(gi);
    localparam logic [7:0] REG_RST  = (gi == 0) ? CTRL1_RST : 8'h00;
    logic [7:0] val_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        val_reg <= REG_RST;
      end else if (commit && addr_reg == REG_ADDR) begin
        val_reg <= rx_byte;
      end
    end
    assign ctrl_q[gi] = val_reg;
  end

  assign ctrl_reg1 = ctrl_q[0];
  assign ctrl_reg2 = ctrl_q[1];
  assign ctrl_reg3 = ctrl_q[2];
  assign ctrl_reg4 = ctrl_q[3];
  assign ctrl_reg5 = ctrl_q[4];
  assign busy      = busy_reg;
  assign miso_oe   = busy_reg;
  assign wr_strobe = wr_strobe_reg;
  assign wr_addr   = wr_addr_reg;

endmodule

// File: tb/tb_gyro_spi_responder.sv
// Directed bench for gyro_spi_responder: drives SPI mode-3 frames and checks
// against a register-map model plus hand-computed literal values.
module tb_gyro_spi_responder;

  localparam int H = 8;  // clk cycles per sclk phase

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b1;
  logic        ss_n = 1'b1;
  logic        mosi = 1'b0;
  logic [15:0] x_in = 16'd0, y_in = 16'd0, z_in = 16'd0;
  logic [7:0]  temp_in = 8'd0;
  logic        miso, miso_oe, wr_strobe, busy;
  logic [7:0]  ctrl_reg1, ctrl_reg2, ctrl_reg3, ctrl_reg4, ctrl_reg5;
  logic [5:0]  wr_addr;

  gyro_spi_responder dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .temp_in(temp_in),
    .ctrl_reg1(ctrl_reg1), .ctrl_reg2(ctrl_reg2), .ctrl_reg3(ctrl_reg3),
    .ctrl_reg4(ctrl_reg4), .ctrl_reg5(ctrl_reg5),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit quiet = 1'b0;
  logic m_busy = 1'b0;
  logic [7:0]  m_ctrl [5];
  logic [15:0] s_x = 16'd0, s_y = 16'd0, s_z = 16'd0;
  logic [7:0]  s_t = 8'd0;
  int strobe_cnt = 0;
  int exp_strobes = 0;
  logic [5:0] strobe_last = 6'd0;
  logic [7:0] tx_buf [16];
  logic [7:0] rx_buf [16];
  bit change_x_mid = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Register image as the master should see it, from the frame snapshot.
  function automatic logic [7:0] model_reg(input logic [5:0] a);
    logic [7:0] img [64];
    for (int k = 0; k < 64; k++) img[k] = 8'h00;
    img[8'h0F] = 8'hD3;
    for (int k = 0; k < 5; k++) img[32 + k] = m_ctrl[k];
    img[8'h26] = s_t;
    img[8'h28] = s_x[7:0];  img[8'h29] = s_x[15:8];
    img[8'h2A] = s_y[7:0];  img[8'h2B] = s_y[15:8];
    img[8'h2C] = s_z[7:0];  img[8'h2D] = s_z[15:8];
    return img[a];
  endfunction

  // Per-cycle compare against the model whenever no edge is in flight.
  always @(negedge clk) begin
    if (quiet && !rst) begin
      chk("ctrl_reg1", ctrl_reg1, m_ctrl[0]);
      chk("ctrl_reg2", ctrl_reg2, m_ctrl[1]);
      chk("ctrl_reg3", ctrl_reg3, m_ctrl[2]);
      chk("ctrl_reg4", ctrl_reg4, m_ctrl[3]);
      chk("ctrl_reg5", ctrl_reg5, m_ctrl[4]);
      chk("busy", busy, m_busy);
      chk("miso_oe", miso_oe, m_busy);
      chk("wr_strobe_quiet", wr_strobe, 1'b0);
      if (!m_busy) chk("miso_idle", miso, 1'b0);
    end
  end

  always @(negedge clk) begin
    if (!rst && wr_strobe) begin
      strobe_cnt++;
      strobe_last = wr_addr;
    end
  end

  // Shifts nb bits of tx MSB first; leaves quiet low after the final rise.
  task automatic send_byte(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = 8'h00;
    for (int b = 7; b > 7 - nb; b--) begin
      sclk = 1'b0;
      mosi = tx[b];
      tick(H);
      rx[b] = miso;
      quiet = 1'b0;
      sclk = 1'b1;
      tick(H);
      if (b > 8 - nb) quiet = 1'b1;
    end
  endtask

  task automatic frame_start();
    quiet = 1'b0;
    ss_n = 1'b0;
    s_x = x_in; s_y = y_in; s_z = z_in; s_t = temp_in;
    m_busy = 1'b1;
    tick(H);
    quiet = 1'b1;
    tick(H);
  endtask

  task automatic frame_end();
    tick(H);
    quiet = 1'b0;
    ss_n = 1'b1;
    m_busy = 1'b0;
    tick(H);
    quiet = 1'b1;
    tick(H);
  endtask

  task automatic run_frame(input int nbytes, input int last_bits);
    logic rw, ms;
    logic [5:0] a;
    logic [7:0] e, r;
    int nb;
    frame_start();
    rw = tx_buf[0][7];
    ms = tx_buf[0][6];
    a  = tx_buf[0][5:0];
    for (int i = 0; i < nbytes; i++) begin
      nb = (i == nbytes - 1) ? last_bits : 8;
      e = model_reg(a);
      send_byte(tx_buf[i], nb, r);
      rx_buf[i] = r;
      if (nb == 8) begin
        if (i == 0) begin
          chk("cmd_miso", r, 8'h00);
        end else begin
          if (rw) begin
            chk("rd_byte", r, e);
          end else begin
            exp_strobes++;
            if (a >= 6'h20 && a <= 6'h24) m_ctrl[int'(a) - 32] = tx_buf[i];
            chk("wr_strobe_cnt", strobe_cnt, exp_strobes);
            chk("wr_addr", strobe_last, a);
          end
          a = ms ? a + 6'd1 : a;
        end
      end
      quiet = 1'b1;
      if (i == 1 && change_x_mid) x_in = 16'hFFFF;
    end
    frame_end();
    chk("strobe_total", strobe_cnt, exp_strobes);
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] burst_exp [6];
    m_ctrl[0] = 8'h07;
    for (int k = 1; k < 5; k++) m_ctrl[k] = 8'h00;

    // Reset values
    tick(5);
    chk("rst_ctrl1", ctrl_reg1, 8'h07);
    chk("rst_ctrl2", ctrl_reg2, 8'h00);
    chk("rst_ctrl5", ctrl_reg5, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_miso", miso, 1'b0);
    chk("rst_miso_oe", miso_oe, 1'b0);
    chk("rst_wr_strobe", wr_strobe, 1'b0);
    chk("rst_wr_addr", wr_addr, 6'd0);
    rst = 1'b0;
    tick(H);
    quiet = 1'b1;

    // WHO_AM_I read
    tx_buf[0] = 8'h8F; tx_buf[1] = 8'h00;
    run_frame(2, 8);
    chk("who_am_i_lit", rx_buf[1], 8'hD3);
    chk("miso_oe_after", miso_oe, 1'b0);

    // Single write to CTRL_REG1, then read it back
    tx_buf[0] = 8'h20; tx_buf[1] = 8'h0F;
    run_frame(2, 8);
    chk("ctrl1_lit", ctrl_reg1, 8'h0F);
    chk("strobe_cnt_lit", strobe_cnt, 1);
    chk("strobe_addr_lit", strobe_last, 6'h20);
    tx_buf[0] = 8'hA0; tx_buf[1] = 8'h00;
    run_frame(2, 8);
    chk("ctrl1_read_lit", rx_buf[1], 8'h0F);

    // Coherent axis burst with x changing mid-frame
    x_in = 16'h1234; y_in = 16'hABCD; z_in = 16'h8001;
    tx_buf[0] = 8'hE8;
    for (int k = 1; k < 7; k++) tx_buf[k] = 8'h00;
    change_x_mid = 1'b1;
    run_frame(7, 8);
    change_x_mid = 1'b0;
    burst_exp[0] = 8'h34; burst_exp[1] = 8'h12; burst_exp[2] = 8'hCD;
    burst_exp[3] = 8'hAB; burst_exp[4] = 8'h01; burst_exp[5] = 8'h80;
    for (int k = 0; k < 6; k++) chk("burst_lit", rx_buf[k + 1], burst_exp[k]);

    // Temperature with MS=0 repeats the address
    temp_in = 8'h19;
    tx_buf[0] = 8'hA6; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    run_frame(3, 8);
    chk("temp_lit0", rx_buf[1], 8'h19);
    chk("temp_lit1", rx_buf[2], 8'h19);

    // Address wrap 0x3F -> 0x00
    tx_buf[0] = 8'hFF; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    run_frame(3, 8);
    chk("wrap_lit0", rx_buf[1], 8'h00);
    chk("wrap_lit1", rx_buf[2], 8'h00);

    // Auto-increment write into CTRL_REG1/2
    tx_buf[0] = 8'h60; tx_buf[1] = 8'hAA; tx_buf[2] = 8'h55;
    run_frame(3, 8);
    chk("ms_wr_ctrl1_lit", ctrl_reg1, 8'hAA);
    chk("ms_wr_ctrl2_lit", ctrl_reg2, 8'h55);

    // Write to a read-only address: strobe only
    tx_buf[0] = 8'h0F; tx_buf[1] = 8'h77;
    run_frame(2, 8);
    chk("ro_wr_addr_lit", strobe_last, 6'h0F);

    // Aborted write after 4 data bits
    tx_buf[0] = 8'h21; tx_buf[1] = 8'hA5;
    run_frame(2, 4);
    chk("abort_ctrl2_lit", ctrl_reg2, 8'h55);
    chk("abort_strobes_lit", strobe_cnt, 4);

    // sclk activity while deselected is ignored
    send_byte(8'h20, 8, r);
    quiet = 1'b1;
    tick(H);
    chk("desel_strobes", strobe_cnt, exp_strobes);

    // Reset in the middle of a WHO_AM_I read, miso high at that moment
    frame_start();
    send_byte(8'h8F, 8, r);
    quiet = 1'b1;
    send_byte(8'h00, 2, r);
    chk("pre_rst_miso", miso, 1'b1);
    rst = 1'b1;
    tick(2);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_miso", miso, 1'b0);
    chk("midrst_miso_oe", miso_oe, 1'b0);
    chk("midrst_ctrl1", ctrl_reg1, 8'h07);
    chk("midrst_ctrl2", ctrl_reg2, 8'h00);
    rst = 1'b0;
    m_ctrl[0] = 8'h07;
    for (int k = 1; k < 5; k++) m_ctrl[k] = 8'h00;
    m_busy = 1'b0;
    tick(2);
    quiet = 1'b1;
    send_byte(8'hFF, 8, r);
    quiet = 1'b1;
    tick(H);
    ss_n = 1'b1;
    tick(2 * H);
    chk("post_rst_strobes", strobe_cnt, exp_strobes);

    // Fresh frame after reset works again
    tx_buf[0] = 8'hA0; tx_buf[1] = 8'h00;
    run_frame(2, 8);
    chk("post_rst_read_lit", rx_buf[1], 8'h07);

    quiet = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
